// File: rtl/cpu_bus_sequencer.sv
// Eight-phase multiplexed CPU bus front end (A1 A2 A3 M1 M2 X1 X2 X3) with halt/resume.
// Every output is registered; its next value is decoded from the next phase and the next latched request.
module cpu_bus_sequencer #(
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned RAM_BANKS = 4,
    parameter int unsigned BANK_W    = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   halt,
    input  logic [3*DATA_W-1:0]    addr,
    input  logic [BANK_W-1:0]      bank_sel,
    input  logic                   io_req,
    input  logic                   wr_req,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic [DATA_W-1:0]      data_i,
    output logic [DATA_W-1:0]      data_o,
    output logic                   data_en,
    output logic                   sync,
    output logic                   rom_cmd,
    output logic [RAM_BANKS-1:0]   ram_cmd_n,
    output logic [2*DATA_W-1:0]    opcode,
    output logic                   instr_valid,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic                   halted
);

    localparam int unsigned ADDR_W = 3 * DATA_W;
    localparam int unsigned OP_W   = 2 * DATA_W;

    typedef enum logic [3:0] {
        HLT, A1, A2, A3, M1, M2, X1, X2, X3
    } phase_e;

    phase_e phase, phase_next;

    logic [ADDR_W-1:0]    addr_q,  addr_next;
    logic [BANK_W-1:0]    bank_q,  bank_next;
    logic                 io_q,    io_next;
    logic                 wr_q,    wr_next;
    logic [DATA_W-1:0]    wdata_q, wdata_next;

    logic [OP_W-1:0]      opcode_next;
    logic [DATA_W-1:0]    rd_data_next;
    logic [DATA_W-1:0]    data_o_next;
    logic                 data_en_next;
    logic                 sync_next;
    logic                 cmd_active;
    logic                 rom_cmd_next;
    logic [RAM_BANKS-1:0] ram_cmd_n_next;
    logic                 instr_valid_next;
    logic                 rd_valid_next;
    logic                 halted_next;

    // Phase sequencing, request latch, capture paths and next-output decode
    always_comb begin
        phase_next       = phase;
        addr_next        = addr_q;
        bank_next        = bank_q;
        io_next          = io_q;
        wr_next          = wr_q;
        wdata_next       = wdata_q;
        opcode_next      = opcode;
        rd_data_next     = rd_data;
        data_o_next      = '0;
        data_en_next     = 1'b0;
        sync_next        = 1'b0;
        cmd_active       = 1'b0;
        rom_cmd_next     = 1'b0;
        ram_cmd_n_next   = '1;
        instr_valid_next = 1'b0;
        rd_valid_next    = 1'b0;
        halted_next      = 1'b0;

        case (phase)
            HLT:     phase_next = halt ? HLT : X3;
            A1:      phase_next = A2;
            A2:      phase_next = A3;
            A3:      phase_next = M1;
            M1:      phase_next = M2;
            M2:      phase_next = X1;
            X1:      phase_next = X2;
            X2:      phase_next = X3;
            X3:      phase_next = halt ? HLT : A1;
            default: phase_next = HLT;
        endcase

        // The request for a cycle is taken only as it starts; later input changes are ignored
        if (phase == X3 && phase_next == A1) begin
            addr_next  = addr;
            bank_next  = bank_sel;
            io_next    = io_req;
            wr_next    = wr_req;
            wdata_next = wr_data;
        end

        if (phase == M1) opcode_next[OP_W-1:DATA_W] = data_i;
        if (phase == M2) opcode_next[DATA_W-1:0]    = data_i;
        if (phase == X2 && !wr_q) rd_data_next = data_i;

        case (phase_next)
            A1: begin
                data_en_next = 1'b1;
                data_o_next  = addr_next[DATA_W-1:0];
            end
            A2: begin
                data_en_next = 1'b1;
                data_o_next  = addr_next[2*DATA_W-1:DATA_W];
            end
            A3: begin
                data_en_next = 1'b1;
                data_o_next  = addr_next[3*DATA_W-1:2*DATA_W];
                cmd_active   = 1'b1;
            end
            M2:  cmd_active       = io_next;
            X1:  instr_valid_next = 1'b1;
            X2: begin
                if (wr_next) begin
                    data_en_next = 1'b1;
                    data_o_next  = wdata_next;
                end
            end
            X3: begin
                sync_next = 1'b1;
                // Only a real X2 read earns a pulse, not the X3 that follows HLT
                rd_valid_next = (phase == X2) && !wr_q;
            end
            HLT:     halted_next = 1'b1;
            default: ;
        endcase

        rom_cmd_next = cmd_active;
        // Out-of-range banks match no line, leaving only the ROM strobe
        for (int b = 0; b < RAM_BANKS; b++) begin
            if (cmd_active && bank_next == BANK_W'(b)) ram_cmd_n_next[b] = 1'b0;
        end
    end

    // Phase register
    always_ff @(posedge clock) begin
        if (reset) phase <= HLT;
        else       phase <= phase_next;
    end

    // Latched request, captured data and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q      <= '0;
            bank_q      <= '0;
            io_q        <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            opcode      <= '0;
            rd_data     <= '0;
            data_o      <= '0;
            data_en     <= 1'b0;
            sync        <= 1'b0;
            rom_cmd     <= 1'b0;
            ram_cmd_n   <= '1;
            instr_valid <= 1'b0;
            rd_valid    <= 1'b0;
            halted      <= 1'b1;
        end else begin
            addr_q      <= addr_next;
            bank_q      <= bank_next;
            io_q        <= io_next;
            wr_q        <= wr_next;
            wdata_q     <= wdata_next;
            opcode      <= opcode_next;
            rd_data     <= rd_data_next;
            data_o      <= data_o_next;
            data_en     <= data_en_next;
            sync        <= sync_next;
            rom_cmd     <= rom_cmd_next;
            ram_cmd_n   <= ram_cmd_n_next;
            instr_valid <= instr_valid_next;
            rd_valid    <= rd_valid_next;
            halted      <= halted_next;
        end
    end

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Self-checking bench for cpu_bus_sequencer: directed and random instruction cycles against a
// transaction-level model; a second instance with three banks covers out-of-range bank_sel.
module tb_cpu_bus_sequencer;

    localparam int unsigned DW  = 4;
    localparam int unsigned NB  = 4;
    localparam int unsigned NB3 = 3;
    localparam int unsigned BW  = 2;

    logic          clock = 1'b0;
    logic          reset, halt, io_req, wr_req;
    logic [11:0]   addr;
    logic [BW-1:0] bank_sel;
    logic [DW-1:0] wr_data, data_i;

    logic [DW-1:0]  data_o, rd_data, data_o3, rd_data3;
    logic           data_en, sync, rom_cmd, instr_valid, rd_valid, halted;
    logic           data_en3, sync3, rom_cmd3, instr_valid3, rd_valid3, halted3;
    logic [NB-1:0]  ram_cmd_n;
    logic [NB3-1:0] ram_cmd_n3;
    logic [7:0]     opcode, opcode3;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]    exp_op;
    logic [3:0]    exp_rd;
    logic [BW-1:0] bank_cur;

    cpu_bus_sequencer #(.DATA_W(DW), .RAM_BANKS(NB), .BANK_W(BW)) u_dut (
        .clock(clock), .reset(reset), .halt(halt), .addr(addr), .bank_sel(bank_sel),
        .io_req(io_req), .wr_req(wr_req), .wr_data(wr_data), .data_i(data_i),
        .data_o(data_o), .data_en(data_en), .sync(sync), .rom_cmd(rom_cmd),
        .ram_cmd_n(ram_cmd_n), .opcode(opcode), .instr_valid(instr_valid),
        .rd_data(rd_data), .rd_valid(rd_valid), .halted(halted)
    );

    cpu_bus_sequencer #(.DATA_W(DW), .RAM_BANKS(NB3), .BANK_W(BW)) u_dut3 (
        .clock(clock), .reset(reset), .halt(halt), .addr(addr), .bank_sel(bank_sel),
        .io_req(io_req), .wr_req(wr_req), .wr_data(wr_data), .data_i(data_i),
        .data_o(data_o3), .data_en(data_en3), .sync(sync3), .rom_cmd(rom_cmd3),
        .ram_cmd_n(ram_cmd_n3), .opcode(opcode3), .instr_valid(instr_valid3),
        .rd_data(rd_data3), .rd_valid(rd_valid3), .halted(halted3)
    );

    always #5 clock = ~clock;

    // Active-low line pattern for a bank command over nb lines
    function automatic int ram_exp(input int nb, input int bank, input logic act);
        int all_ones;
        all_ones = (1 << nb) - 1;
        if (act && bank < nb) return all_ones & ~(1 << bank);
        return all_ones;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic scramble;
        addr     = 12'($urandom);
        bank_sel = BW'($urandom);
        io_req   = 1'($urandom);
        wr_req   = 1'($urandom);
        wr_data  = DW'($urandom);
        data_i   = DW'($urandom);
    endtask

    task automatic check_phase(input string tag, input logic [3:0] e_do, input logic e_en,
                               input logic e_sync, input logic e_cmd, input logic e_iv,
                               input logic e_rv, input logic e_hl);
        logic [25:0] o4, x4;
        logic [24:0] o3, x3;
        o4 = {data_o, data_en, sync, rom_cmd, ram_cmd_n, instr_valid, rd_valid, halted, opcode, rd_data};
        x4 = {e_do, e_en, e_sync, e_cmd, 4'(ram_exp(NB, int'(bank_cur), e_cmd)),
              e_iv, e_rv, e_hl, exp_op, exp_rd};
        o3 = {data_o3, data_en3, sync3, rom_cmd3, ram_cmd_n3, instr_valid3, rd_valid3, halted3,
              opcode3, rd_data3};
        x3 = {e_do, e_en, e_sync, e_cmd, 3'(ram_exp(NB3, int'(bank_cur), e_cmd)),
              e_iv, e_rv, e_hl, exp_op, exp_rd};
        n_checks++;
        assert (o4 === x4) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, o4, x4);
        end
        n_checks++;
        assert (o3 === x3) else begin
            n_errors++;
            $error("FAIL %s/3banks: observed=%h expected=%h", tag, o3, x3);
        end
    endtask

    // One instruction cycle, entered while the DUT sits in X3; inputs are scrambled mid-cycle
    task automatic run_cycle(input logic [11:0] a, input logic [1:0] b, input logic io,
                             input logic wr, input logic [3:0] wd, input logic [3:0] dm1,
                             input logic [3:0] dm2, input logic [3:0] dx2,
                             input logic halt_m1, input logic abort_x2);
        addr = a; bank_sel = b; io_req = io; wr_req = wr; wr_data = wd;
        data_i = DW'($urandom);
        bank_cur = b;
        for (int k = 0; k < 3; k++) begin
            tick;
            scramble;
            check_phase($sformatf("A%0d", k + 1), a[k*4 +: 4], 1'b1, 1'b0, (k == 2), 1'b0, 1'b0, 1'b0);
        end
        tick;
        scramble;
        data_i = dm1;
        if (halt_m1) halt = 1'b1;
        check_phase("M1", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        scramble;
        data_i = dm2;
        exp_op[7:4] = dm1;
        check_phase("M2", 4'h0, 1'b0, 1'b0, io, 1'b0, 1'b0, 1'b0);
        tick;
        scramble;
        exp_op[3:0] = dm2;
        check_phase("X1", 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick;
        scramble;
        data_i = dx2;
        check_phase("X2", wr ? wd : 4'h0, wr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (abort_x2) begin
            reset = 1'b1;
            tick;
            exp_op = 8'h00;
            exp_rd = 4'h0;
            check_phase("abort_hlt", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            return;
        end
        tick;
        if (!wr) exp_rd = dx2;
        check_phase("X3", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, !wr, 1'b0);
    endtask

    // Enter HLT from X3, hold for n cycles, then resume into X3
    task automatic halt_phase(input int n);
        tick;
        check_phase("hlt_enter", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < n; i++) begin
            scramble;
            tick;
            check_phase("hlt_hold", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        halt = 1'b0;
        scramble;
        tick;
        check_phase("resume_x3", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; halt = 1'b1;
        addr = '0; bank_sel = '0; io_req = 1'b0; wr_req = 1'b0; wr_data = '0; data_i = '0;
        exp_op = 8'h00; exp_rd = 4'h0; bank_cur = '0;
        tick;
        tick;
        check_phase("reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        reset = 1'b0;
        halt  = 1'b0;
        tick;
        check_phase("first_x3", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        run_cycle(12'hABC, 2'd1, 1'b0, 1'b0, 4'h0, 4'h5, 4'h3, 4'h9, 1'b0, 1'b0);
        run_cycle(12'h123, 2'd3, 1'b1, 1'b1, 4'h6, 4'h7, 4'h2, 4'h4, 1'b0, 1'b0);
        run_cycle(12'h456, 2'd3, 1'b0, 1'b0, 4'h1, 4'h1, 4'h8, 4'h5, 1'b1, 1'b0);
        halt_phase(3);
        run_cycle(12'h789, 2'd2, 1'b1, 1'b0, 4'hE, 4'hC, 4'hD, 4'hA, 1'b0, 1'b0);
        run_cycle(12'hDEF, 2'd0, 1'b0, 1'b0, 4'h2, 4'hF, 4'hE, 4'h7, 1'b0, 1'b1);
        reset = 1'b0;
        halt  = 1'b0;
        tick;
        check_phase("post_abort_x3", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            logic hm;
            hm = ($urandom % 5) == 0;
            run_cycle(12'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
                      4'($urandom), 4'($urandom), 4'($urandom), hm, 1'b0);
            if (hm) halt_phase(int'($urandom % 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
